// File: rtl/ascii_cmd_sequencer.sv
// rtl/ascii_cmd_sequencer.sv - two-key command sequencer for UART keyboard bytes
// Maps each byte to a key code, pairs select/target keys and presents them on a valid/ready port.
module ascii_cmd_sequencer #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int TMR_W          = 26,
   parameter int ERR_W          = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_done_tick,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [4:0]       cmd_first,
   output logic [4:0]       cmd_second,
   output logic [4:0]       sel_code,
   output logic             busy,
   output logic             timeout_tick,
   output logic             cancel_tick,
   output logic             overrun_tick,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;

   localparam logic [7:0]       ESC      = 8'h1B;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [4:0]       first_q, first_d;
   logic [4:0]       second_q, second_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             to_q, to_d;
   logic             can_q, can_d;
   logic             ovr_q, ovr_d;
   logic             err_inc;
   logic [4:0]       key;

   // '1'-'9' -> 1..9, 'a'-'i' -> 10..18, anything else -> 0
   always_comb begin
      key = 5'd0;
      if (rx_data >= 8'h31 && rx_data <= 8'h39) begin
         key = 5'(rx_data - 8'h30);
      end else if (rx_data >= 8'h61 && rx_data <= 8'h69) begin
         key = 5'(rx_data - 8'h57);
      end
   end

   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      second_d = second_q;
      tmr_d    = tmr_q;
      to_d     = 1'b0;
      can_d    = 1'b0;
      ovr_d    = 1'b0;
      err_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_done_tick) begin
               if (key != 5'd0) begin
                  first_d = key;
                  tmr_d   = '0;
                  state_d = WAIT;
               end else if (rx_data != ESC) begin
                  err_inc = 1'b1;
               end
            end
         end
         WAIT: begin
            tmr_d = tmr_q + TMR_W'(1);
            // A byte arriving on the last timer cycle wins over the timeout
            if (rx_done_tick) begin
               if (rx_data == ESC) begin
                  can_d   = 1'b1;
                  state_d = IDLE;
               end else if (key == 5'd0 || key == first_q) begin
                  err_inc = 1'b1;
               end else begin
                  second_d = key;
                  state_d  = EMIT;
               end
            end else if (tmr_q == TMR_LAST) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (rx_done_tick) begin
               ovr_d = 1'b1;
            end
            if (cmd_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      err_d = (err_inc && err_q != {ERR_W{1'b1}}) ? err_q + ERR_W'(1) : err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         first_q  <= '0;
         second_q <= '0;
         tmr_q    <= '0;
         err_q    <= '0;
         to_q     <= 1'b0;
         can_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         second_q <= second_d;
         tmr_q    <= tmr_d;
         err_q    <= err_d;
         to_q     <= to_d;
         can_q    <= can_d;
         ovr_q    <= ovr_d;
      end
   end

   assign cmd_valid    = (state_q == EMIT);
   assign busy         = (state_q != IDLE);
   assign sel_code     = (state_q == WAIT) ? first_q : 5'd0;
   assign cmd_first    = first_q;
   assign cmd_second   = second_q;
   assign timeout_tick = to_q;
   assign cancel_tick  = can_q;
   assign overrun_tick = ovr_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_ascii_cmd_sequencer.sv
// tb/tb_ascii_cmd_sequencer.sv - directed scoreboard bench for ascii_cmd_sequencer
module tb_ascii_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done_tick = 1'b0;
   logic       cmd_ready = 1'b0;

   logic       cmd_valid, busy, timeout_tick, cancel_tick, overrun_tick;
   logic [4:0] cmd_first, cmd_second, sel_code;
   logic [7:0] err_count;

   logic       s_valid, s_busy, s_to, s_ca, s_ov;
   logic [4:0] s_first, s_second, s_sel;
   logic [1:0] s_err;

   int tests = 0;
   int fails = 0;
   int valid_cycles = 0, n_to = 0, n_ca = 0, n_ov = 0;
   int vc_snap, k;
   logic [9:0] exp_q[$];
   logic [9:0] obs_q[$];
   logic [7:0] bad [5] = '{8'h00, 8'h30, 8'h6A, 8'h20, 8'h7F};

   ascii_cmd_sequencer #(.TIMEOUT_CYCLES(16), .TMR_W(5), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
      .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_first(cmd_first),
      .cmd_second(cmd_second), .sel_code(sel_code), .busy(busy),
      .timeout_tick(timeout_tick), .cancel_tick(cancel_tick),
      .overrun_tick(overrun_tick), .err_count(err_count)
   );

   ascii_cmd_sequencer #(.TIMEOUT_CYCLES(16), .TMR_W(5), .ERR_W(2)) dut_sat (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
      .cmd_ready(cmd_ready), .cmd_valid(s_valid), .cmd_first(s_first),
      .cmd_second(s_second), .sel_code(s_sel), .busy(s_busy),
      .timeout_tick(s_to), .cancel_tick(s_ca),
      .overrun_tick(s_ov), .err_count(s_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_valid) valid_cycles++;
      if (cmd_valid && cmd_ready) obs_q.push_back({cmd_first, cmd_second});
      if (timeout_tick) n_to++;
      if (cancel_tick) n_ca++;
      if (overrun_tick) n_ov++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
   endtask

   task automatic drain();
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         chk("cmd_pair", {22'd0, obs_q.pop_front()}, {22'd0, exp_q.pop_front()});
      end
      chk("cmd_leftover_obs", obs_q.size(), 0);
      chk("cmd_leftover_exp", exp_q.size(), 0);
   endtask

   initial begin
      step(1);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel_code, 0);
      chk("rst_err", err_count, 0);
      chk("rst_first", cmd_first, 0);
      chk("rst_pulses", {timeout_tick, cancel_tick, overrun_tick}, 0);
      reset = 1'b0;
      step(1);

      // basic command
      cmd_ready = 1'b1;
      exp_q.push_back({5'd3, 5'd12});
      tick(8'h33);
      tick(8'h63);
      chk("basic_valid", cmd_valid, 1);
      chk("basic_busy", busy, 1);
      step(1);
      chk("basic_valid_drop", cmd_valid, 0);
      chk("basic_idle", busy, 0);
      drain();

      // backpressure and overrun
      cmd_ready = 1'b0;
      exp_q.push_back({5'd1, 5'd18});
      tick(8'h31);
      tick(8'h69);
      step(5);
      tick(8'h35);
      chk("ovr_pulse", overrun_tick, 1);
      step(14);
      chk("bp_valid", cmd_valid, 1);
      chk("bp_first", cmd_first, 1);
      chk("bp_second", cmd_second, 18);
      chk("bp_ovr_count", n_ov, 1);
      cmd_ready = 1'b1;
      step(1);
      chk("bp_idle", busy, 0);
      chk("bp_valid_drop", cmd_valid, 0);
      chk("bp_err", err_count, 0);
      drain();

      // timeout
      tick(8'h32);
      chk("to_sel", sel_code, 2);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1);
         if (timeout_tick) begin
            k = i;
            break;
         end
      end
      chk("to_latency", k, 16);
      chk("to_sel_clear", sel_code, 0);
      chk("to_idle", busy, 0);

      // tick on the final timer cycle beats the timeout
      exp_q.push_back({5'd2, 5'd10});
      tick(8'h32);
      step(15);
      tick(8'h61);
      chk("tie_valid", cmd_valid, 1);
      chk("tie_no_to", timeout_tick, 0);
      step(2);
      chk("tie_to_count", n_to, 1);
      drain();

      // errors and cancel
      vc_snap = valid_cycles;
      tick(8'h7A);
      chk("err_idle", err_count, 1);
      tick(8'h34);
      tick(8'h34);
      tick(8'h1B);
      chk("cancel_pulse", cancel_tick, 1);
      chk("err_dup", err_count, 2);
      chk("cancel_idle", busy, 0);
      step(2);
      chk("cancel_count", n_ca, 1);
      chk("err_no_valid", valid_cycles, vc_snap);

      // saturation on the narrow counter
      chk("sat_pre", s_err, 2);
      for (int i = 0; i < 5; i++) tick(bad[i]);
      chk("sat_wide", err_count, 7);
      chk("sat_narrow", s_err, 3);

      // reset while a command is pending
      cmd_ready = 1'b0;
      tick(8'h37);
      tick(8'h39);
      chk("rst_pending", cmd_valid, 1);
      reset = 1'b1;
      #1;
      chk("rst_async_valid", cmd_valid, 0);
      chk("rst_mid_first", {cmd_first, cmd_second, sel_code}, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_err", err_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cmd_ready = 1'b1;
      exp_q.push_back({5'd8, 5'd9});
      tick(8'h38);
      tick(8'h39);
      step(2);
      drain();
      chk("final_ovr_count", n_ov, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ascii_cmd_sequencer.md
Name: ascii_cmd_sequencer

Overview:
Sequences keyboard bytes arriving from the UART receiver into two-key commands (select, then target) for the downstream game/board logic.
Each byte is mapped to a key code with the team's ASCII key mapping: '1'-'9' map to 1-9, 'a'-'i' map to 10-18, and every other byte maps to 0 (invalid).
The block owns the key-entry state machine, the entry timeout, cancel handling and error accounting.
It presents completed commands on a valid/ready interface.

Parameters:
TIMEOUT_CYCLES, 50_000_000, cycles allowed between first and second key (1 s at 50 MHz)
TMR_W, 26, timeout counter width; must satisfy 2^TMR_W >= TIMEOUT_CYCLES
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received ASCII byte, valid only when rx_done_tick=1
rx_done_tick  in  1  one-cycle strobe per received byte
cmd_ready  in  1  downstream accepts command
cmd_valid  out  1  command available
cmd_first  out  5  first key code, 1-18
cmd_second  out  5  second key code, 1-18
sel_code  out  5  pending first key while waiting; 0 otherwise
busy  out  1  1 in any state other than IDLE
timeout_tick  out  1  one-cycle pulse on entry timeout
cancel_tick  out  1  one-cycle pulse on ESC cancel
overrun_tick  out  1  one-cycle pulse when a byte is dropped in EMIT
err_count  out  ERR_W  saturating count of invalid or duplicate keys

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; timer 0; err_count 0.
- Key decode is combinational on rx_data. "Valid key" means code != 0. ESC is byte 0x1B.
- IDLE:
  - tick with a valid key: latch code into first register; sel_code = code; timer cleared; go to WAIT on the next edge.
  - tick with ESC: no action, no pulse.
  - tick with any other byte: err_count +1.
- WAIT:
  - The timer increments each cycle.
  - tick with a valid key different from first: latch second; go to EMIT. cmd_valid=1 on the cycle after the tick (1-cycle latency).
  - tick with a valid key equal to first: err_count +1; stay in WAIT; timer is not restarted.
  - tick with ESC: cancel_tick=1 for one cycle; go to IDLE; sel_code=0.
  - tick with an invalid byte: err_count +1; stay in WAIT.
  - Timeout: timer == TIMEOUT_CYCLES-1 with no tick that cycle gives timeout_tick=1 for one cycle, IDLE, sel_code=0.
  - A tick on the timeout cycle takes priority: it is processed as above and no timeout fires.
- EMIT:
  - cmd_valid=1; cmd_first and cmd_second are stable until transfer; sel_code=0.
  - Transfer happens when cmd_valid and cmd_ready are both 1 at a rising edge. cmd_valid=0 next cycle; state IDLE.
  - cmd_ready may be held high continuously; a command then lasts exactly one cycle.
  - Any tick while in EMIT, including the transfer cycle, is dropped: overrun_tick=1 for one cycle, err_count unchanged.
- cmd_first and cmd_second hold their last values after transfer. They are meaningful only while cmd_valid=1.
- err_count saturates at 2^ERR_W-1 and never wraps.
- Tick pulses are registered, one cycle after the causing event. At most one pulse per cycle.
- Reset asserted mid-operation: immediate return to IDLE. An in-flight command is discarded; cmd_valid drops asynchronously.
- No internal buffering beyond one command.

Test Plan:
- Basic command: ticks '3' (0x33) then 'c' (0x63), cmd_ready=1 -> one cycle of cmd_valid=1 with first=3, second=12, starting 1 cycle after second tick; busy back to 0.
- Backpressure and overrun: '1','i' with cmd_ready=0 for 20 cycles, tick '5' during EMIT -> cmd_valid held with first=1, second=18; overrun_tick pulse; after ready, state IDLE with err_count=0.
- Timeout (TIMEOUT_CYCLES=16): '2' then nothing -> timeout_tick exactly 16 cycles after entering WAIT; sel_code 2 -> 0.
- Timeout tie (TIMEOUT_CYCLES=16): tick 'a' on the final cycle -> command (2,10) emitted; no timeout_tick.
- Errors: 'z' in IDLE, then '4','4', then ESC -> err_count=2; cancel_tick once; no cmd_valid.
- Error saturation (ERR_W=2): 5 invalid bytes -> err_count=3.
- Reset during EMIT: pending (7,9) with reset pulsed -> cmd_valid=0 immediately; all outputs 0; next '8','9' yields (8,9).
